// File: rtl/shift_pkg.sv
// Shared mode encodings and pipeline slicing helpers for the shift_pipe family.
package shift_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t SHIFT_SHL  = 2'b00;
    localparam mode_t SHIFT_LSHR = 2'b01;
    localparam mode_t SHIFT_ASHR = 2'b10;
    localparam mode_t SHIFT_ROTL = 2'b11;

    function automatic int shamt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    // Amount bits handled per stage, rounded up so every bit is covered.
    function automatic int stage_bits(input int aw, input int stages);
        return (aw + stages - 1) / stages;
    endfunction

    // The trailing stage may get fewer bits, or none at all.
    function automatic int stage_nb(input int aw, input int b, input int k);
        int rem;
        rem = aw - k * b;
        if (rem <= 0) return 0;
        if (rem < b)  return rem;
        return b;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered barrel slice: applies amount bits [LO +: NB], one cycle latency.
// Stalls only when full and downstream is not ready, so a streaming pipe has no bubbles.
module shift_stage
    import shift_pkg::*;
#(
    parameter int W  = 32,
    parameter int AW = 5,
    parameter int LO = 0,
    parameter int NB = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_dat,
    input  logic [AW-1:0] in_amt,
    input  mode_t         in_mode,
    input  logic          in_sign,
    input  logic          in_oor,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_dat,
    output logic [AW-1:0] out_amt,
    output mode_t         out_mode,
    output logic          out_sign,
    output logic          out_oor
);

    logic           vld_q, vld_d;
    logic [W-1:0]   dat_q, dat_d;
    logic [AW-1:0]  amt_q, amt_d;
    mode_t          mode_q, mode_d;
    logic           sign_q, sign_d;
    logic           oor_q, oor_d;
    logic           load;
    logic [W-1:0]   shifted;
    logic [2*W-1:0] ext;

    always_comb begin
        shifted = in_dat;
        ext     = '0;
        for (int j = 0; j < NB; j++) begin
            if (in_amt[LO + j]) begin
                case (in_mode)
                    SHIFT_LSHR: shifted = shifted >> (1 << (LO + j));
                    SHIFT_ASHR: begin
                        // Fill comes from the carried sign, not the current MSB.
                        ext     = {{W{in_sign}}, shifted} >> (1 << (LO + j));
                        shifted = ext[W-1:0];
                    end
`ifdef SHIFT_ROTATE_EN
                    SHIFT_ROTL: shifted = (shifted << (1 << (LO + j)))
                                        | (shifted >> (W - (1 << (LO + j))));
`endif
                    default:    shifted = shifted << (1 << (LO + j));
                endcase
            end
        end
    end

    always_comb begin
        in_rdy = ~vld_q | out_rdy;
        load   = in_vld & in_rdy;
        vld_d  = in_rdy ? in_vld : vld_q;
        dat_d  = load ? shifted : dat_q;
        amt_d  = load ? in_amt  : amt_q;
        mode_d = load ? in_mode : mode_q;
        sign_d = load ? in_sign : sign_q;
        oor_d  = load ? in_oor  : oor_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            dat_q  <= '0;
            amt_q  <= '0;
            mode_q <= SHIFT_SHL;
            sign_q <= 1'b0;
            oor_q  <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            dat_q  <= dat_d;
            amt_q  <= amt_d;
            mode_q <= mode_d;
            sign_q <= sign_d;
            oor_q  <= oor_d;
        end
    end

    assign out_vld  = vld_q;
    assign out_dat  = dat_q;
    assign out_amt  = amt_q;
    assign out_mode = mode_q;
    assign out_sign = sign_q;
    assign out_oor  = oor_q;

endmodule

// File: rtl/shift_pipe.sv
// Elastic shl/lshr/ashr over a lhs/rhs/mode join; STAGES cycles latency, 1 result/cycle.
// result_ready stalls ripple back through the slices; SHIFT_ROTATE_EN adds mode 11 rotate-left.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int DATA_TYPE = 32,
    parameter int STAGES    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_TYPE-1:0] lhs,
    input  logic                 lhs_valid,
    output logic                 lhs_ready,
    input  logic [DATA_TYPE-1:0] rhs,
    input  logic                 rhs_valid,
    output logic                 rhs_ready,
    input  logic [1:0]           mode,
    input  logic                 mode_valid,
    output logic                 mode_ready,
    output logic [DATA_TYPE-1:0] result,
    output logic                 result_valid,
    input  logic                 result_ready
);

    localparam int SHAMT_W = shamt_w(DATA_TYPE);
    localparam int B       = stage_bits(SHAMT_W, STAGES);
    localparam logic [DATA_TYPE-1:0] W_VAL = DATA_TYPE'(DATA_TYPE);

    logic                 vld_s  [0:STAGES];
    logic                 rdy_s  [0:STAGES];
    logic [DATA_TYPE-1:0] dat_s  [0:STAGES];
    logic [SHAMT_W-1:0]   amt_s  [0:STAGES];
    mode_t                mode_s [0:STAGES];
    logic                 sign_s [0:STAGES];
    logic                 oor_s  [0:STAGES];

    mode_t                mode_in;
    logic [SHAMT_W-1:0]   amt_in;
    logic                 oor_in;
    logic [SHAMT_W-1:0]   amt_unused;
`ifdef SHIFT_ROTATE_EN
    logic [DATA_TYPE-1:0] rot_rem;
`endif

    always_comb begin
        mode_in = mode;
        amt_in  = rhs[SHAMT_W-1:0];
        oor_in  = (rhs >= W_VAL);
`ifdef SHIFT_ROTATE_EN
        rot_rem = rhs % W_VAL;
        if (mode == SHIFT_ROTL) begin
            amt_in = rot_rem[SHAMT_W-1:0];
            oor_in = 1'b0;
        end
`else
        if (mode == SHIFT_ROTL) mode_in = SHIFT_SHL;
`endif
    end

    // Each channel is ready only when the other two are offering, so tokens move together.
    assign vld_s[0]   = lhs_valid & rhs_valid & mode_valid;
    assign lhs_ready  = rdy_s[0] & rhs_valid & mode_valid;
    assign rhs_ready  = rdy_s[0] & lhs_valid & mode_valid;
    assign mode_ready = rdy_s[0] & lhs_valid & rhs_valid;

    assign dat_s[0]      = lhs;
    assign amt_s[0]      = amt_in;
    assign mode_s[0]     = mode_in;
    assign sign_s[0]     = lhs[DATA_TYPE-1];
    assign oor_s[0]      = oor_in;
    assign rdy_s[STAGES] = result_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .W  (DATA_TYPE),
            .AW (SHAMT_W),
            .LO (k * B),
            .NB (stage_nb(SHAMT_W, B, k))
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .in_vld   (vld_s[k]),
            .in_rdy   (rdy_s[k]),
            .in_dat   (dat_s[k]),
            .in_amt   (amt_s[k]),
            .in_mode  (mode_s[k]),
            .in_sign  (sign_s[k]),
            .in_oor   (oor_s[k]),
            .out_vld  (vld_s[k+1]),
            .out_rdy  (rdy_s[k+1]),
            .out_dat  (dat_s[k+1]),
            .out_amt  (amt_s[k+1]),
            .out_mode (mode_s[k+1]),
            .out_sign (sign_s[k+1]),
            .out_oor  (oor_s[k+1])
        );
    end

    assign amt_unused = amt_s[STAGES];

    always_comb begin
        result = dat_s[STAGES];
        if (oor_s[STAGES])
            result = (mode_s[STAGES] == SHIFT_ASHR) ? {DATA_TYPE{sign_s[STAGES]}} : '0;
    end

    assign result_valid = vld_s[STAGES];

endmodule
